sum_ctrl_unit: RTL

- Control FSM that sits directly upstream of the GDP data_path and drives all of its control inputs.
- Computes run_sum = n + (n-1) + ... + 1, using the data_path register file: rf[SUM_ADDR] holds the sum, rf[N_ADDR] holds the count.
- Uses the data_path n_is_0 status to terminate the loop.
- Provides a start/done handshake toward the enclosing system.

---
 rtl/sum_ctrl_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sum_ctrl_unit.sv
`timescale 1ns/1ps
// sum_ctrl_unit: Moore control FSM that drives a GDP data_path to compute
// run_sum = n + (n-1) + ... + 1 using rf[SUM_ADDR] (sum) and rf[N_ADDR] (count).
// Ports:
//   clock, reset (sync, active-high), start, n_is_0 : inputs
//   done, busy                                      : handshake/status outputs
//   input_enable_mux, WE, WA, RAE, RAA, RBE, RBA    : data_path control
//   alu_op, shift_op, output_enable_buf             : data_path control
//   cycles (only with SUM_CTRL_CYCLE_COUNT_EN)      : busy-cycle counter
// Optional feature macro: SUM_CTRL_CYCLE_COUNT_EN adds the cycles port.
module sum_ctrl_unit #(
    parameter logic [1:0] SUM_ADDR = 2'b00,
    parameter logic [1:0] N_ADDR   = 2'b01
`ifdef SUM_CTRL_CYCLE_COUNT_EN
    ,
    parameter int CYC_W = 16
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       n_is_0,
    output logic       done,
    output logic       busy,
    output logic       input_enable_mux,
    output logic       WE,
    output logic [1:0] WA,
    output logic       RAE,
    output logic [1:0] RAA,
    output logic       RBE,
    output logic [1:0] RBA,
    output logic [2:0] alu_op,
    output logic [1:0] shift_op,
    output logic       output_enable_buf
`ifdef SUM_CTRL_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0] cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_LOAD = 3'd2,
        S_TEST = 3'd3,
        S_ADD  = 3'd4,
        S_DEC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_ZERO = 3'b101;
    localparam logic [2:0] ALU_DEC  = 3'b111;

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = start ? S_INIT : S_IDLE;
            S_INIT: state_d = S_LOAD;
            S_LOAD: state_d = S_TEST;
            S_TEST: state_d = n_is_0 ? S_DONE : S_ADD;
            S_ADD:  state_d = S_DEC;
            S_DEC:  state_d = S_TEST;
            // Leaving DONE needs start low, so a held start never retriggers
            S_DONE: state_d = start ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; unused addresses stay 2'b00
    always_comb begin
        done              = 1'b0;
        busy              = 1'b0;
        input_enable_mux  = 1'b0;
        WE                = 1'b0;
        WA                = 2'b00;
        RAE               = 1'b0;
        RAA               = 2'b00;
        RBE               = 1'b0;
        RBA               = 2'b00;
        alu_op            = ALU_PASS;
        shift_op          = 2'b00;
        output_enable_buf = 1'b0;
        case (state_q)
            S_INIT: begin
                busy   = 1'b1;
                WE     = 1'b1;
                WA     = SUM_ADDR;
                RAE    = 1'b1;
                RAA    = SUM_ADDR;
                RBE    = 1'b1;
                RBA    = SUM_ADDR;
                alu_op = ALU_ZERO;
            end
            S_LOAD: begin
                busy             = 1'b1;
                input_enable_mux = 1'b1;
                WE               = 1'b1;
                WA               = N_ADDR;
            end
            S_TEST: begin
                busy = 1'b1;
                RAE  = 1'b1;
                RAA  = N_ADDR;
            end
            S_ADD: begin
                busy   = 1'b1;
                WE     = 1'b1;
                WA     = SUM_ADDR;
                RAE    = 1'b1;
                RAA    = SUM_ADDR;
                RBE    = 1'b1;
                RBA    = N_ADDR;
                alu_op = ALU_ADD;
            end
            S_DEC: begin
                busy   = 1'b1;
                WE     = 1'b1;
                WA     = N_ADDR;
                RAE    = 1'b1;
                RAA    = N_ADDR;
                alu_op = ALU_DEC;
            end
            S_DONE: begin
                done              = 1'b1;
                RAE               = 1'b1;
                RAA               = SUM_ADDR;
                output_enable_buf = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef SUM_CTRL_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    // Clear on launch, count busy edges, saturate at all-ones
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && start) begin
            cyc_d = '0;
        end else if (busy && cyc_q != {CYC_W{1'b1}}) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    assign cycles = cyc_q;
`endif

endmodule
